rx_serial_os: RTL and testbench
===============================

# rx_serial_os

Parametrised asynchronous serial receiver, successor of the single-mode UART receiver. It runs a 2-flop input synchroniser and samples three times per bit at a configurable oversampling rate, taking a majority vote. It supports none/odd/even parity and 1 or 2 stop bits, and detects framing errors. Received words go to the consumer through a valid/ready handshake with overrun flagging, and the block sits between the `rxd` pin and any word-level consumer.

## Interface

Parameters:
- `BAUD_RATE`, 9600, line bit rate.
- `CLOCK_HZ`, 50_000_000, system clock frequency.
- `N_BITS`, 8, data bits per frame; legal range 5..9.
- `PARITY`, 1; 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1; legal values 1 or 2.
- `OVERSAMPLE`, 16; ticks per bit, even, ≥ 8.

Ports:
- `clock` in 1: single system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `rxd` in 1: asynchronous serial line, idle high.
- `ready` in 1: consumer accepts the current word.
- `valid` out 1: word available.
- `data` out N_BITS: received word, LSB received first.
- `parity_error` out 1: parity mismatch on the current word; always 0 when PARITY = 0.
- `framing_error` out 1: a stop bit sampled low on the current word.
- `overrun` out 1: at least one frame was lost while `valid` was held.
- `busy` out 1: frame reception in progress, i.e. state ≠ idle.
- `db_estado` out 4: current FSM state code, for debug.

## Operation

- Tick generator:
  - Divider `DIV = CLOCK_HZ / (BAUD_RATE*OVERSAMPLE)`, using integer truncation.
  - One-cycle `tick` pulse every DIV cycles.
  - The divider is cleared when leaving idle, so bit timing is phase-aligned to the detected start edge.
- Synchroniser: two flops, both reset to 1. The FSM sees only the synchronised `rxd_s`.
- Per-bit sampling:
  - A tick counter runs 0..OVERSAMPLE-1 within each bit.
  - Samples are taken at counts OS/2-1, OS/2 and OS/2+1.
  - The bit value is the majority of the three samples.
  - The bit ends at count OS-1, except where noted below.
- FSM states and codes: idle 0, start 1, data 2, parity 3, stop 4, store 5.
  - idle → start when `rxd_s` = 0.
  - start: if the majority is 1, this is a false start; go to idle with no output. Otherwise go to data at the end of the bit.
  - data: shift N_BITS bits LSB-first. After the last bit, go to parity if PARITY ≠ 0, else to stop.
  - parity: compute the error as follows, then go to stop.
    - odd: error = XOR(data, p) == 0.
    - even: error = XOR(data, p) == 1.
  - stop: sample STOP_BITS bits; any low majority sets the frame's framing error. Move to store right after the last sample of the last stop bit (count OS/2+1), not at bit end, to allow early resynchronisation.
  - store: lasts one clock, then always → idle.
- Output register (on the store cycle):
  - If `valid` = 0, or `valid` & `ready` in the same cycle: load `data`, `parity_error` and `framing_error`, and set `valid` = 1.
  - If `valid` = 1 and `ready` = 0: discard the new frame and set `overrun` = 1. Outputs keep the older word.
- Handshake:
  - Transfer occurs on a cycle with `valid` & `ready`.
  - `valid` clears on the next cycle unless a store happens on the same cycle.
  - `overrun` is sticky and clears only on a transfer or on reset.
  - `ready` while `valid` = 0 has no effect.
- Reset:
  - Applies from any state, including mid-frame.
  - FSM → idle; counters and divider → 0; synchroniser → 1.
  - `valid`, `data`, `parity_error`, `framing_error`, `overrun`, `busy` → 0; `db_estado` → 0.
  - A partially received frame is dropped.

## Timing

- Input latency: the falling edge on `rxd` reaches the FSM 2 cycles later, as start is entered.
- Frame latency: `valid` rises 1 cycle after store. Store is entered ≈ (1 + N_BITS + P + STOP_BITS − 0.5) bit periods after the start edge, where P = 1 if PARITY ≠ 0.
- Minimum valid glitch rejection: a low pulse shorter than OS/2−1 ticks is treated as a false start.
- Back-to-back frames: a start edge arriving ≥ 1 cycle after store is detected.
- All outputs are registered; there are no combinational paths from `rxd` or `ready` to any output.

## Test plan

Bench parameters: CLOCK_HZ = 1_536_000, BAUD_RATE = 9600, OVERSAMPLE = 16, which gives DIV = 10 and 160 cycles per bit.

1. Good odd-parity frame. PARITY = 1, STOP_BITS = 1, `ready` = 0. Send 0x55 with p = 1 and stop = 1.
   → `valid` = 1 with `data` = 0x55 and both error flags 0.
   → Pulse `ready` for one cycle; `valid` is 0 the next cycle.
2. Parity error. Send 0xA3 with p = 1; 0xA3 has four ones, so odd parity requires p = 1 — invert it and send p = 0.
   → `data` = 0xA3, `parity_error` = 1, `framing_error` = 0.
3. Framing error. PARITY = 0, STOP_BITS = 2. Send 0x3C with the second stop bit low.
   → `data` = 0x3C, `framing_error` = 1.
4. False start. Drive `rxd` low for 40 cycles, then high.
   → Start is entered, then returns to idle; `db_estado` = 0 and `busy` = 0.
   → `valid` never rises.
5. Overrun. Hold `ready` = 0 and send 0x11 then 0x22.
   → `data` stays 0x11 and `overrun` = 1.
   → Pulse `ready`: `valid` and `overrun` both 0 the next cycle.
   → A third frame 0x33 is then received cleanly.
6. Mid-frame reset. Assert `reset` for 1 cycle during the data state.
   → All outputs are 0 the next cycle and `db_estado` = 0.
   → A subsequent frame 0xF0 is received correctly.

Source files
------------

// File: rtl/rx_serial_os.sv
// Oversampling asynchronous serial receiver: 2-flop synchroniser, 3-sample majority vote,
// optional parity, 1/2 stop bits, framing/overrun detection and valid/ready output.
module rx_serial_os #(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_HZ   = 50_000_000,
  parameter int N_BITS     = 8,
  parameter int PARITY     = 1,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rxd,
  input  logic              ready,
  output logic              valid,
  output logic [N_BITS-1:0] data,
  output logic              parity_error,
  output logic              framing_error,
  output logic              overrun,
  output logic              busy,
  output logic [3:0]        db_estado
);

  localparam int unsigned DIV   = CLOCK_HZ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BC_W  = $clog2(N_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  SAMP0    = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  SAMP1    = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0]  SAMP2    = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(N_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_START  = 4'd1,
    ST_DATA   = 4'd2,
    ST_PARITY = 4'd3,
    ST_STOP   = 4'd4,
    ST_STORE  = 4'd5
  } state_t;

  state_t state, nxt;

  logic              rxd_m, rxd_s;
  logic [DIV_W-1:0]  div_cnt;
  logic [OS_W-1:0]   os_cnt;
  logic [1:0]        samp;
  logic [BC_W-1:0]   bit_cnt;
  logic              stop_cnt;
  logic [N_BITS-1:0] shreg;
  logic              perr_f, ferr_f;
  logic              tick, decide, bit_end, maj;

  assign tick    = (div_cnt == DIV_LAST);
  assign decide  = tick && (os_cnt == SAMP2);
  assign bit_end = tick && (os_cnt == OS_LAST);
  // Third sample is taken live from rxd_s at the decision tick.
  assign maj     = (samp[0] & samp[1]) | (samp[0] & rxd_s) | (samp[1] & rxd_s);

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:   if (!rxd_s) nxt = ST_START;
      ST_START: begin
        if (decide && maj) nxt = ST_IDLE;
        else if (bit_end)  nxt = ST_DATA;
      end
      ST_DATA:   if (bit_end && bit_cnt == BIT_LAST)
                   nxt = (PARITY != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) nxt = ST_STOP;
      // Leave right after the last stop sample so the next start edge can be caught early.
      ST_STOP:   if (decide && stop_cnt == STOP_LAST) nxt = ST_STORE;
      ST_STORE:  nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    db_estado = state;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rxd_m    <= 1'b1;
      rxd_s    <= 1'b1;
      div_cnt  <= '0;
      os_cnt   <= '0;
      samp     <= '1;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      perr_f   <= 1'b0;
      ferr_f   <= 1'b0;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      if (state == ST_IDLE) begin
        div_cnt  <= '0;
        os_cnt   <= '0;
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        perr_f   <= 1'b0;
        ferr_f   <= 1'b0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
        if (tick && os_cnt == SAMP0) samp[0] <= rxd_s;
        if (tick && os_cnt == SAMP1) samp[1] <= rxd_s;
        if (decide) begin
          case (state)
            ST_DATA:   shreg <= {maj, shreg[N_BITS-1:1]};
            ST_PARITY: perr_f <= (PARITY == 1) ? ~(^shreg ^ maj) : (^shreg ^ maj);
            ST_STOP:   if (!maj) ferr_f <= 1'b1;
            default: ;
          endcase
        end
        if (bit_end) begin
          case (state)
            ST_DATA: bit_cnt  <= bit_cnt + 1'b1;
            ST_STOP: stop_cnt <= stop_cnt + 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid         <= 1'b0;
      data          <= '0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (valid && ready) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
      if (state == ST_STORE) begin
        if (!valid || ready) begin
          valid         <= 1'b1;
          data          <= shreg;
          parity_error  <= perr_f;
          framing_error <= ferr_f;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_serial_os.sv
// Directed bench for rx_serial_os: odd-parity/1-stop instance (a) and no-parity/2-stop instance (b).
module tb_rx_serial_os;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic line  = 1'b1;
  int   tgt   = 0;
  logic rxd_a, rxd_b;
  logic ready_a = 1'b0, ready_b = 1'b0;

  logic       valid_a, perr_a, ferr_a, ovr_a, busy_a;
  logic [7:0] data_a;
  logic [3:0] st_a;
  logic       valid_b, perr_b, ferr_b, ovr_b, busy_b;
  logic [7:0] data_b;
  logic [3:0] st_b;

  int n_cmp = 0;
  int n_bad = 0;

  assign rxd_a = (tgt == 0) ? line : 1'b1;
  assign rxd_b = (tgt == 1) ? line : 1'b1;

  always #5 clock = ~clock;

  rx_serial_os #(.BAUD_RATE(9600), .CLOCK_HZ(1_536_000), .N_BITS(8), .PARITY(1),
                 .STOP_BITS(1), .OVERSAMPLE(16)) dut_a (
    .clock(clock), .reset(reset), .rxd(rxd_a), .ready(ready_a), .valid(valid_a),
    .data(data_a), .parity_error(perr_a), .framing_error(ferr_a), .overrun(ovr_a),
    .busy(busy_a), .db_estado(st_a));

  rx_serial_os #(.BAUD_RATE(9600), .CLOCK_HZ(1_536_000), .N_BITS(8), .PARITY(0),
                 .STOP_BITS(2), .OVERSAMPLE(16)) dut_b (
    .clock(clock), .reset(reset), .rxd(rxd_b), .ready(ready_b), .valid(valid_b),
    .data(data_b), .parity_error(perr_b), .framing_error(ferr_b), .overrun(ovr_b),
    .busy(busy_b), .db_estado(st_b));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic b);
    line = b;
    repeat (160) @(negedge clock);
  endtask

  // par < 0 means no parity bit on the line.
  task automatic send_frame(input logic [7:0] d, input int par, input logic s1,
                            input int nstop, input logic s2);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    if (par >= 0) bit_time(par[0]);
    bit_time(s1);
    if (nstop == 2) bit_time(s2);
    line = 1'b1;
  endtask

  function automatic logic cur_valid(input int which);
    return (which == 0) ? valid_a : valid_b;
  endfunction

  task automatic wait_valid(input string tag, input int which);
    int k = 0;
    while (cur_valid(which) !== 1'b1 && k < 3000) begin
      @(negedge clock);
      k++;
    end
    check_eq(tag, {31'd0, cur_valid(which)}, 32'd1);
  endtask

  task automatic ack(input string tag, input int which);
    if (which == 0) ready_a = 1'b1; else ready_b = 1'b1;
    @(negedge clock);
    ready_a = 1'b0;
    ready_b = 1'b0;
    check_eq(tag, {31'd0, cur_valid(which)}, 32'd0);
  endtask

  initial begin
    logic saw;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_eq("rst_valid", valid_a, 0);
    check_eq("rst_data",  data_a, 0);
    check_eq("rst_busy",  busy_a, 0);
    check_eq("rst_state", st_a, 0);
    check_eq("rst_ovr",   ovr_a, 0);
    repeat (20) @(negedge clock);

    // Good odd-parity frame
    send_frame(8'h55, 1, 1'b1, 1, 1'b1);
    wait_valid("t1_valid", 0);
    check_eq("t1_data", data_a, 32'h55);
    check_eq("t1_perr", perr_a, 0);
    check_eq("t1_ferr", ferr_a, 0);
    ack("t1_ack", 0);

    // Parity error: 0xA3 with inverted parity bit
    repeat (50) @(negedge clock);
    send_frame(8'hA3, 0, 1'b1, 1, 1'b1);
    wait_valid("t2_valid", 0);
    check_eq("t2_data", data_a, 32'hA3);
    check_eq("t2_perr", perr_a, 1);
    check_eq("t2_ferr", ferr_a, 0);
    ack("t2_ack", 0);

    // Framing error on second stop bit (instance b)
    tgt = 1;
    repeat (50) @(negedge clock);
    send_frame(8'h3C, -1, 1'b1, 2, 1'b0);
    repeat (300) @(negedge clock);
    wait_valid("t3_valid", 1);
    check_eq("t3_data", data_b, 32'h3C);
    check_eq("t3_ferr", ferr_b, 1);
    check_eq("t3_perr", perr_b, 0);
    ack("t3_ack", 1);
    tgt = 0;

    // False start
    repeat (50) @(negedge clock);
    line = 1'b0;
    repeat (20) @(negedge clock);
    check_eq("t4_in_start", st_a, 1);
    repeat (20) @(negedge clock);
    line = 1'b1;
    saw = 1'b0;
    repeat (200) begin
      @(negedge clock);
      saw |= valid_a;
    end
    check_eq("t4_state", st_a, 0);
    check_eq("t4_busy", busy_a, 0);
    check_eq("t4_no_valid", saw, 0);

    // Overrun
    send_frame(8'h11, 1, 1'b1, 1, 1'b1);
    send_frame(8'h22, 1, 1'b1, 1, 1'b1);
    repeat (20) @(negedge clock);
    check_eq("t5_valid", valid_a, 1);
    check_eq("t5_data", data_a, 32'h11);
    check_eq("t5_ovr", ovr_a, 1);
    ack("t5_ack", 0);
    check_eq("t5_ovr_clr", ovr_a, 0);
    repeat (50) @(negedge clock);
    send_frame(8'h33, 1, 1'b1, 1, 1'b1);
    wait_valid("t5_3_valid", 0);
    check_eq("t5_3_data", data_a, 32'h33);
    check_eq("t5_3_ovr", ovr_a, 0);
    check_eq("t5_3_perr", perr_a, 0);

    // Mid-frame reset with a word still held in the output register
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    repeat (80) @(negedge clock);
    check_eq("t6_in_data", st_a, 2);
    reset = 1'b1;
    line  = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_eq("t6_valid", valid_a, 0);
    check_eq("t6_data", data_a, 0);
    check_eq("t6_state", st_a, 0);
    check_eq("t6_busy", busy_a, 0);
    check_eq("t6_flags", {ovr_a, perr_a, ferr_a}, 0);
    repeat (400) @(negedge clock);
    send_frame(8'hF0, 1, 1'b1, 1, 1'b1);
    wait_valid("t6_f0_valid", 0);
    check_eq("t6_f0_data", data_a, 32'hF0);
    check_eq("t6_f0_err", {perr_a, ferr_a}, 0);
    ack("t6_ack", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
